// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
// Shared definitions for the down_timer block and its counter stages.
//
// Contents:
//   state_e      - timer control state (IDLE / RUN / EXPIRED)
//   NIBBLE_W     - width of one cascaded counter stage
//   NIBBLES_MIN  - smallest legal number of stages
//   NIBBLES_MAX  - largest legal number of stages
// -----------------------------------------------------------------------------
package down_timer_pkg;

   // Encodings are fixed so that software or a waveform viewer reading the
   // raw state bits sees the documented values.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   localparam int unsigned NIBBLE_W    = 4;
   localparam int unsigned NIBBLES_MIN = 1;
   localparam int unsigned NIBBLES_MAX = 8;

endpackage : down_timer_pkg

// File: rtl/down_counter_stage.sv
// -----------------------------------------------------------------------------
// down_counter_stage
// One 4-bit synchronous down-counter slice, cascadable through its borrow
// output. A slice decrements only when both enables are high; cascading bo
// into the next slice's ent forms a combinational lookahead borrow chain, so
// every slice of a wide counter updates on the same clock edge.
//
// Ports:
//   clk   in   1  clock, rising edge
//   rst   in   1  asynchronous active-high reset, clears the count
//   load  in   1  synchronous parallel load of D (wins over counting)
//   D     in   4  parallel load value
//   enp   in   1  count enable shared by all slices
//   ent   in   1  borrow-in from the less significant slice (1 for slice 0)
//   Q     out  4  current slice count
//   bo    out  1  borrow-out: slice is zero and borrow-in is active
// -----------------------------------------------------------------------------
module down_counter_stage
   import down_timer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [NIBBLE_W-1:0] D,
   input  logic                enp,
   input  logic                ent,
   output logic [NIBBLE_W-1:0] Q,
   output logic                bo
);

   logic [NIBBLE_W-1:0] count_q;
   logic [NIBBLE_W-1:0] count_d;

   // NOTE: every variable written in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = D;
      end else if (enp && ent) begin
         // A slice wraps 0 -> 15 on its own; the top prevents the whole
         // counter from wrapping by dropping enp once every slice is zero.
         count_d = count_q - NIBBLE_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign Q  = count_q;
   assign bo = (count_q == '0) && ent;

endmodule : down_counter_stage

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Programmable down-counting timer built from NIBBLES cascaded 4-bit slices.
// start loads a period P and enters RUN; each enabled cycle in RUN the count
// steps toward zero. The enabled cycle that finds the count at zero raises a
// one-cycle terminal-count pulse and either reloads the captured period
// (periodic=1) or parks in EXPIRED holding zero (periodic=0). stop aborts to
// IDLE holding the count. With en held high in periodic mode tc repeats every
// P+1 cycles.
//
// Parameters:
//   NIBBLES  number of 4-bit slices, legal 1..8; count width W = 4*NIBBLES
//
// Ports:
//   clk       in   1  clock, all state changes on the rising edge
//   rst       in   1  asynchronous active-high reset
//   P         in   W  period, captured on start
//   start     in   1  load P into count and period register, enter RUN
//   stop      in   1  abort to IDLE, count and period hold (beats start)
//   en        in   1  count enable / prescaler tick, ignored outside RUN
//   periodic  in   1  1 = reload at zero, 0 = one-shot; sampled every cycle
//   Q         out  W  current count (registered)
//   tc        out  1  registered one-cycle terminal-count pulse
//   running   out  1  high in RUN
//   expired   out  1  high in EXPIRED
// -----------------------------------------------------------------------------
module down_timer
   import down_timer_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLE_W * NIBBLES
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] P,
   input  logic         start,
   input  logic         stop,
   input  logic         en,
   input  logic         periodic,
   output logic [W-1:0] Q,
   output logic         tc,
   output logic         running,
   output logic         expired
);

   // ---------------------------------------------------------------------
   // Control state, captured period and terminal-count register
   // ---------------------------------------------------------------------
   state_e       state_q, state_d;
   logic [W-1:0] per_q,   per_d;
   logic         tc_q,    tc_d;

   // ---------------------------------------------------------------------
   // Counter datapath
   // ---------------------------------------------------------------------
   logic [W-1:0]     count;     // concatenated slice outputs
   logic [NIBBLES:0] borrow;    // borrow[i] feeds slice i; top bit = all zero
   logic             zero;      // whole count is zero
   logic             count_tick;// an enabled RUN cycle with no start/stop
   logic             reload;    // periodic reload at zero
   logic             load;      // parallel load of every slice
   logic             enp;       // shared slice decrement enable
   logic [W-1:0]     load_val;  // P on start, captured period on reload

   // stop beats start beats counting, so a counting cycle needs both quiet.
   assign count_tick = (state_q == ST_RUN) && en && !stop && !start;

   // With slice 0's borrow-in tied high, the last borrow-out is the AND of
   // every slice being zero, i.e. a full-width zero detect.
   assign borrow[0] = 1'b1;
   assign zero      = borrow[NIBBLES];

   assign reload   = count_tick && zero && periodic;
   assign load     = (start && !stop) || reload;
   assign load_val = start ? P : per_q;

   // Counting stops at zero rather than wrapping; zero is handled above as
   // the reload / expiry point instead of as a decrement.
   assign enp = count_tick && !zero;

   for (genvar i = 0; i < NIBBLES; i++) begin : g_stage
      down_counter_stage u_stage (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .D    (load_val[NIBBLE_W*i +: NIBBLE_W]),
         .enp  (enp),
         .ent  (borrow[i]),
         .Q    (count[NIBBLE_W*i +: NIBBLE_W]),
         .bo   (borrow[i+1])
      );
   end : g_stage

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      tc_d    = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
      end else if (start) begin
         state_d = ST_RUN;
         per_d   = P;
      end else if (count_tick && zero) begin
         // Terminal count: pulse tc; one-shot parks in EXPIRED with the
         // count held at zero, periodic stays in RUN (slices reload).
         tc_d = 1'b1;
         if (!periodic) begin
            state_d = ST_EXPIRED;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         tc_q    <= tc_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: all straight from registers
   // ---------------------------------------------------------------------
   assign Q       = count;
   assign tc      = tc_q;
   assign running = (state_q == ST_RUN);
   assign expired = (state_q == ST_EXPIRED);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
// Self-checking bench for down_timer (NIBBLES=4, W=16). A behavioural model
// keeps the count and period as plain numbers and applies the timer's rules
// once per clock edge; each scenario task compares the DUT against it and
// against fixed expectations (tc cadence, borrow values, priority results).
// -----------------------------------------------------------------------------
module tb_down_timer;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] P;
   logic         start, stop, en, periodic;
   logic [W-1:0] q;
   logic         tc, running, expired;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: count/period as numbers, mode as two flags.
   logic [W-1:0] m_cnt;
   logic [W-1:0] m_per;
   bit           m_run, m_exp, m_tc;

   down_timer #(.NIBBLES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .P        (P),
      .start    (start),
      .stop     (stop),
      .en       (en),
      .periodic (periodic),
      .Q        (q),
      .tc       (tc),
      .running  (running),
      .expired  (expired)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_cnt = '0; m_per = '0; m_run = 0; m_exp = 0; m_tc = 0;
   endtask

   // One clock edge of the timer rules, using the inputs present at the edge.
   task automatic model_edge();
      m_tc = 0;
      if (stop) begin
         m_run = 0; m_exp = 0;
      end else if (start) begin
         m_cnt = P; m_per = P; m_run = 1; m_exp = 0;
      end else if (m_run && en) begin
         if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
         end else begin
            m_tc = 1;
            if (periodic) m_cnt = m_per;
            else begin m_run = 0; m_exp = 1; end
         end
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after it.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; en = 0; periodic = 0; P = '0;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      model_reset();
      @(negedge clk); @(negedge clk);
      checks++;
      if ({q, tc, running, expired} !== {16'h0, 3'b000}) begin
         failures++;
         $display("FAIL reset_state: Q=%h tc=%b run=%b exp=%b, want all zero", q, tc, running, expired);
      end
      @(posedge clk); #1 rst = 1'b0;

      P = 16'h0123; start = 1; cycle(); start = 0; P = 16'(($urandom));
      cycle(); cycle();
      checks++;
      if ({q, running} !== {16'h0123, 1'b1}) begin
         failures++;
         $display("FAIL reset_prerun: Q=%h run=%b, want Q=0123 run=1", q, running);
      end
      // Assert reset between edges; outputs must clear without a clock.
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({q, tc, running, expired} !== {16'h0, 3'b000}) begin
         failures++;
         $display("FAIL reset_async: Q=%h tc=%b run=%b exp=%b, want all zero", q, tc, running, expired);
      end
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_one_shot();
      int tc_count = 0;
      int tc_at    = -1;
      idle_inputs();
      P = 16'd3; en = 1; start = 1;
      cycle();
      start = 0; P = 16'(($urandom));
      checks++;
      if (q !== 16'd3) begin
         failures++;
         $display("FAIL one_shot_load: Q=%h, want 0003", q);
      end
      for (int i = 1; i <= 14; i++) begin
         cycle();
         if (tc) begin tc_count++; tc_at = i; end
         checks++;
         if ({q, tc, running, expired} !== {m_cnt, m_tc, m_run, m_exp}) begin
            failures++;
            $display("FAIL one_shot cyc=%0d: Q=%h tc=%b run=%b exp=%b, want Q=%h tc=%b run=%b exp=%b",
                     i, q, tc, running, expired, m_cnt, m_tc, m_run, m_exp);
         end
      end
      checks++;
      if (tc_count !== 1 || tc_at !== 4) begin
         failures++;
         $display("FAIL one_shot_tc: pulses=%0d at=%0d, want 1 pulse at 4", tc_count, tc_at);
      end
      checks++;
      if ({q, expired, running} !== {16'h0, 2'b10}) begin
         failures++;
         $display("FAIL one_shot_expired: Q=%h exp=%b run=%b, want Q=0 exp=1 run=0", q, expired, running);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_periodic();
      int tc_times[$];
      idle_inputs();
      P = 16'h0010; en = 1; periodic = 1; start = 1;
      cycle();
      start = 0;
      cycle();
      checks++;
      if (q !== 16'h000F) begin
         failures++;
         $display("FAIL periodic_borrow: Q=%h, want 000F", q);
      end
      for (int i = 2; i <= 80 && tc_times.size() < 4; i++) begin
         cycle();
         if (tc) tc_times.push_back(i);
         // Once a period is underway, scribble over P: it must not matter.
         if (tc_times.size() >= 2) P = 16'(($urandom));
         checks++;
         if ({q, tc, running, expired} !== {m_cnt, m_tc, m_run, m_exp}) begin
            failures++;
            $display("FAIL periodic cyc=%0d: Q=%h tc=%b run=%b exp=%b, want Q=%h tc=%b run=%b exp=%b",
                     i, q, tc, running, expired, m_cnt, m_tc, m_run, m_exp);
         end
      end
      checks++;
      if (tc_times.size() != 4) begin
         failures++;
         $display("FAIL periodic_count: tc pulses=%0d in 80 cycles, want 4", tc_times.size());
      end else begin
         checks++;
         if (tc_times[0] != 17) begin
            failures++;
            $display("FAIL periodic_first: first tc at %0d, want 17", tc_times[0]);
         end
         for (int k = 1; k < 4; k++) begin
            checks++;
            if (tc_times[k] - tc_times[k-1] != 17) begin
               failures++;
               $display("FAIL periodic_interval: interval %0d = %0d, want 17", k, tc_times[k] - tc_times[k-1]);
            end
         end
      end
      stop = 1; cycle(); stop = 0;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_enable_gating();
      int en_cycles = 0;
      int tc_after  = -1;
      idle_inputs();
      P = 16'd5; start = 1;
      cycle();
      start = 0;
      for (int i = 0; i < 30 && tc_after < 0; i++) begin
         en = (i % 2 == 0);
         if (en) en_cycles++;
         cycle();
         if (tc) tc_after = en_cycles;
         checks++;
         if ({q, tc, running, expired} !== {m_cnt, m_tc, m_run, m_exp}) begin
            failures++;
            $display("FAIL en_gate cyc=%0d: Q=%h tc=%b run=%b exp=%b, want Q=%h tc=%b run=%b exp=%b",
                     i, q, tc, running, expired, m_cnt, m_tc, m_run, m_exp);
         end
      end
      checks++;
      if (tc_after != 6) begin
         failures++;
         $display("FAIL en_gate_tc: tc after %0d enabled cycles, want 6", tc_after);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_priority();
      logic [W-1:0] held;
      idle_inputs();
      P = 16'd100; en = 1; periodic = 1'($urandom); start = 1;
      cycle();
      start = 0;
      repeat (3) cycle();
      held = q;
      start = 1; stop = 1; P = 16'd7;
      cycle();
      start = 0; stop = 0;
      checks++;
      if ({q, running, expired, tc} !== {held, 3'b000}) begin
         failures++;
         $display("FAIL prio_stop_start: Q=%h run=%b exp=%b tc=%b, want Q=%h idle", q, running, expired, tc, held);
      end
      repeat (3) cycle();
      checks++;
      if ({q, running} !== {held, 1'b0}) begin
         failures++;
         $display("FAIL prio_idle_hold: Q=%h run=%b, want Q=%h run=0", q, running, held);
      end
      // Reach EXPIRED quickly, then restart from it.
      P = 16'd0; periodic = 0; start = 1;
      cycle();
      start = 0;
      cycle();
      checks++;
      if ({expired, tc} !== 2'b11) begin
         failures++;
         $display("FAIL prio_to_expired: exp=%b tc=%b, want 1 1", expired, tc);
      end
      P = 16'd2; start = 1;
      cycle();
      start = 0;
      checks++;
      if ({q, running, expired} !== {16'd2, 2'b10}) begin
         failures++;
         $display("FAIL prio_restart: Q=%h run=%b exp=%b, want Q=0002 run=1 exp=0", q, running, expired);
      end
      stop = 1; cycle(); stop = 0;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_p_zero();
      idle_inputs();
      P = 16'd0; periodic = 1; en = 1; start = 1;
      cycle();
      start = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if ({q, tc, running} !== {16'h0, 2'b11}) begin
            failures++;
            $display("FAIL p0_periodic cyc=%0d: Q=%h tc=%b run=%b, want Q=0 tc=1 run=1", i, q, tc, running);
         end
      end
      periodic = 0;
      cycle();
      checks++;
      if ({tc, expired} !== 2'b11) begin
         failures++;
         $display("FAIL p0_oneshot_tc: tc=%b exp=%b, want 1 1", tc, expired);
      end
      cycle();
      checks++;
      if ({q, tc, expired} !== {16'h0, 2'b01}) begin
         failures++;
         $display("FAIL p0_oneshot_after: Q=%h tc=%b exp=%b, want Q=0 tc=0 exp=1", q, tc, expired);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 600; i++) begin
         stop  = ($urandom_range(0, 31) == 0);
         start = ($urandom_range(0, 11) == 0);
         en    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) periodic = ~periodic;
         P = ($urandom_range(0, 3) == 0) ? 16'(($urandom)) : 16'($urandom_range(0, 12));
         cycle();
         checks++;
         if ({q, tc, running, expired} !== {m_cnt, m_tc, m_run, m_exp}) begin
            failures++;
            $display("FAIL random cyc=%0d: Q=%h tc=%b run=%b exp=%b, want Q=%h tc=%b run=%b exp=%b",
                     i, q, tc, running, expired, m_cnt, m_tc, m_run, m_exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_enable_gating();
      test_priority();
      test_p_zero();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_down_timer

// File: doc/down_timer.md
# down_timer

Programmable synchronous down-counting timer built from cascaded 4-bit down-counter stages. It is the count-down counterpart of the team's 4-bit up-counter parts: it loads a period, decrements toward zero, and signals terminal count. In one-shot mode it stops at zero; in periodic mode it auto-reloads. It sits beside the CPU model as a tick or delay source.

## Interface
Parameters:
- NIBBLES, 4, number of cascaded 4-bit stages; count width W = 4*NIBBLES (legal 1..8)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- P  in  W  period value, captured on start
- start  in  1  load P into count and period register, enter RUN
- stop  in  1  abort: enter IDLE, hold count
- en  in  1  count enable (prescaler tick); ignored outside RUN
- periodic  in  1  1 = auto-reload at zero, 0 = one-shot; sampled every cycle
- Q  out  W  current count
- tc  out  1  registered one-cycle terminal-count pulse
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED

## Operation
- States: IDLE (reset state), RUN, EXPIRED; running/expired decode state directly.
- Priority each edge: stop > start > count.
- stop=1 (any state): next state IDLE; count and period register hold; tc=0.
- start=1, stop=0 (any state, including RUN): count<=P, per<=P, next state RUN; no decrement that cycle.
- RUN, en=1, count!=0: count<=count-1.
- RUN, en=1, count==0, periodic=1: count<=per, tc=1 next cycle, stay RUN.
- RUN, en=1, count==0, periodic=0: count holds 0, tc=1 next cycle, next state EXPIRED.
- RUN, en=0: hold everything.
- IDLE/EXPIRED: count holds; en ignored; only start leaves them.
- Decrement is modulo-free: count never wraps below 0. Zero is the reload/expiry point.
- Period with en held high and periodic=1: tc every P+1 cycles; P=0 gives tc every cycle.
- Changes to P after start do not affect the running period.

## Timing
- Reset values: Q=0, per=0, state IDLE, tc=0, running=0, expired=0.
- rst acts immediately and asynchronously. Release is synchronous to the next clk edge. Reset mid-RUN discards count and period.
- start to first decrement: start at edge k sets Q=P after k. The first decrement is at edge k+1 if en=1.
- tc is high for exactly the one cycle after the edge where count==0 and en=1 in RUN. tc never stays high for two consecutive cycles unless P=0 periodic with en held high.
- Q, running and expired are registered; no combinational path from inputs to outputs.
- The borrow chain is combinational lookahead across stages. All stages update on the same edge, with no ripple clocking.

## Structure
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2), NIBBLES bounds constant.
- Sub-module down_counter_stage: 4-bit synchronous down stage.
  - Ports: clk, rst, load, D[3:0], enp, ent, Q[3:0], bo.
  - bo = (Q==0) & ent.
  - Decrements when enp&ent, wrapping 0 to 15.
- Top generates NIBBLES stages. Stage 0 ent = 1; stage i+1 ent = stage i bo. enp = RUN & en & ~zero.
- zero = bo of the last stage.
- Load is driven for start or periodic reload. D mux selects P or per.

## Test plan
- Reset: assert rst mid-RUN with Q=0x0123 → Q=0, IDLE, tc=0 immediately, without waiting for clk.
- One-shot: NIBBLES=4, P=3, periodic=0, en=1 → Q sequence 3,2,1,0. tc pulses once, 4 cycles after the start edge. Then expired=1 and Q stays 0 for 10 more cycles.
- Periodic plus nibble borrow: P=0x0010, periodic=1, en=1.
  - Q goes 0x10, then 0x0F (cross-stage borrow), down to 0, then back to 0x10.
  - tc period is exactly 17 cycles.
  - Changing P mid-run does not alter the period.
- Enable gating: P=5, en toggles 1,0,1,0 → Q decrements only on en=1 cycles. tc arrives after 6 enabled cycles.
- Priority: start and stop together in RUN → IDLE with Q held. start while EXPIRED with P=2 → RUN, Q=2.
- Edge case: P=0, periodic=1, en=1 → tc high every cycle and Q stays 0. P=0, periodic=0 → a single tc, then EXPIRED.
